vga_graph: RTL and testbench
============================

Name: vga_graph

Overview:
- Raster pixel-colour generator for the graph/tour display.
- Scans a 256x256 logical frame at one pixel per clock and colours each pixel:
  - white if it lies on a node marker;
  - green if it lies on a tour edge;
  - black otherwise.
- Node coordinates and the visiting order (path) come in as flat packed buses from the solver.
- RGB output feeds the downstream VGA output/scaling stage.

Parameters:
- N_NODES, 64, number of nodes and path entries.
- COORD_W, 8, coordinate width; the frame is 2^COORD_W square.
- IDX_W, 6, node index width (log2 N_NODES).
- COLOR_W, 16, width of each colour channel.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- xs  in  [N_NODES-1:0][COORD_W-1:0]  x coordinate of node i is xs[i].
- ys  in  [N_NODES-1:0][COORD_W-1:0]  y coordinate of node i is ys[i].
- path  in  [N_NODES-1:0][IDX_W-1:0]  tour order; path[k] is the k-th visited node index.
- R  out  COLOR_W  red channel of the current pixel.
- G  out  COLOR_W  green channel of the current pixel.
- B  out  COLOR_W  blue channel of the current pixel.

Behaviour:
- One clock domain. Reset is synchronous, active-low: any rising clk edge with rst==0 sets px=0, py=0, R=G=B=0.
- Internal scan counters px, py (COORD_W bits each).
- On each edge with rst==1:
  - px increments.
  - px wraps 255->0; on that wrap py increments.
  - py wraps 255->0.
- Frame period is 65536 clocks; no blanking intervals.
- Output latency is one clock: on each rst==1 edge, R/G/B are registered with the colour of the pixel (px,py) held before that edge.
  - After reset release, edge n (n=1,2,...) presents pixel index n-1, i.e. x=(n-1)%256, y=((n-1)/256)%256.
- Node hit: exists i with |px-xs[i]|<=1 and |py-ys[i]|<=1.
  - Compare unsigned, no wrap-around; markers clip at frame edges.
- Edge hit: exists segment k (0..N_NODES-1) from node a=path[k] to node b=path[(k+1) mod N_NODES], i.e. a closed tour, such that both of these hold:
  - px lies within [min(xa,xb), max(xa,xb)] and py within [min(ya,yb), max(ya,yb)];
  - with dx=xb-xa, dy=yb-ya, cross=(px-xa)*dy-(py-ya)*dx (signed, at least 2*COORD_W+2 bits), the condition |2*cross| <= max(|dx|,|dy|) holds.
  - A zero-length segment (a==b, or identical coordinates) hits only its single point.
- Colour priority:
  - node: R=G=B=16'hFFFF;
  - else edge: R=0, G=16'hFFFF, B=0;
  - else all 0.
- Inputs are sampled combinationally every pixel. Changes to xs/ys/path take effect from the next evaluated pixel; frames are not double-buffered.
- Duplicate indices in path are legal and are drawn as given.
- Reset asserted mid-frame: the next edge clears outputs and counters. Scanning restarts at (0,0) on the first edge with rst==1.

Decomposition:
- Package vga_graph_pkg holds:
  - N_NODES, COORD_W, IDX_W, COLOR_W;
  - colour constants COL_WHITE, COL_GREEN, COL_BLACK;
  - typedefs coord_t, idx_t, color_t.
- Sub-module vga_graph_seg_hit: purely combinational, one instance per segment via generate.
  - Inputs: pixel, endpoint A and endpoint B.
  - Output: hit bit (bounding box plus cross-product test).
- Node-marker test and the final OR-reduction stay in the top level.

Test Plan:
- Reset check:
  - Stimulus: rst=0 for 3 cycles, then rst=1.
  - Required: R=G=B=0 during reset; first post-reset output corresponds to pixel (0,0); pixel (255,255) appears on edge 65536; edge 65537 shows (0,0) again.
- Single cluster:
  - Stimulus: all xs=ys=10, path[k]=k.
  - Required: pixels (9..11, 9..11) are white; (12,10) and (8,8) are black; no green anywhere.
- Horizontal edge:
  - Stimulus: node1=(100,0), all other nodes at (0,0), path identity.
  - Required: (50,0) green; (50,1) black; (100,1) white; (101,0) white; (102,0) black.
- Diagonal edge:
  - Stimulus: node0=(0,0), node1=(32,27), rest at (0,0).
  - Required: (16,13) green (|2*16|=32<=32); (16,20) black; (33,28) white.
- Path order:
  - Stimulus: same coordinates as the diagonal-edge test, but path[0]=1, path[1]=0, rest 0.
  - Required: identical image to the diagonal-edge test.
  - Then set node1 to (200,200) mid-frame; required: the change is visible from the next pixel.
- Full-load stress:
  - Stimulus: xs[i]=(32*i)%256, ys[i]=(27*i)%256, path[i]=i; run 70000 clocks.
  - Required: no X on R/G/B after reset; (32,27) white; (16,13) green.

Source files
------------

// File: rtl/vga_graph_pkg.sv
//------------------------------------------------------------------------------
// Module : vga_graph_pkg
// Brief  : Shared sizes, colour constants and types for the graph raster.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package vga_graph_pkg;

    localparam int N_NODES = 64;
    localparam int COORD_W = 8;
    localparam int IDX_W   = 6;
    localparam int COLOR_W = 16;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t COL_WHITE = 16'hFFFF;
    localparam color_t COL_GREEN = 16'hFFFF;
    localparam color_t COL_BLACK = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/vga_graph_seg_hit.sv
//------------------------------------------------------------------------------
// Module : vga_graph_seg_hit
// Brief  : Combinational test of whether a pixel lies on segment A-B.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vga_graph_seg_hit
    import vga_graph_pkg::*;
(
    input  coord_t px,
    input  coord_t py,
    input  coord_t xa,
    input  coord_t ya,
    input  coord_t xb,
    input  coord_t yb,
    output logic   hit
);

    localparam int D_W = COORD_W + 1;
    localparam int CW  = 2 * COORD_W + 4;

    coord_t                w_xlo, w_xhi, w_ylo, w_yhi;
    logic                  w_in_box;
    logic signed [D_W-1:0] w_dx, w_dy, w_rx, w_ry;
    logic signed [CW-1:0]  w_dx_e, w_dy_e, w_rx_e, w_ry_e, w_cross;
    logic [CW-1:0]         w_mag;
    logic [CW:0]           w_twice;
    logic [D_W-1:0]        w_adx, w_ady, w_span;

    always_comb begin
        w_xlo    = (xa < xb) ? xa : xb;
        w_xhi    = (xa < xb) ? xb : xa;
        w_ylo    = (ya < yb) ? ya : yb;
        w_yhi    = (ya < yb) ? yb : ya;
        w_in_box = (px >= w_xlo) && (px <= w_xhi) && (py >= w_ylo) && (py <= w_yhi);

        w_dx = $signed({1'b0, xb}) - $signed({1'b0, xa});
        w_dy = $signed({1'b0, yb}) - $signed({1'b0, ya});
        w_rx = $signed({1'b0, px}) - $signed({1'b0, xa});
        w_ry = $signed({1'b0, py}) - $signed({1'b0, ya});

        w_dx_e = {{(CW-D_W){w_dx[D_W-1]}}, w_dx};
        w_dy_e = {{(CW-D_W){w_dy[D_W-1]}}, w_dy};
        w_rx_e = {{(CW-D_W){w_rx[D_W-1]}}, w_rx};
        w_ry_e = {{(CW-D_W){w_ry[D_W-1]}}, w_ry};

        // Distance-to-line test without division: |2*cross| against the major axis span.
        w_cross = w_rx_e * w_dy_e - w_ry_e * w_dx_e;
        w_mag   = w_cross[CW-1] ? -w_cross : w_cross;
        w_twice = {w_mag, 1'b0};

        w_adx  = w_dx[D_W-1] ? -w_dx : w_dx;
        w_ady  = w_dy[D_W-1] ? -w_dy : w_dy;
        w_span = (w_adx > w_ady) ? w_adx : w_ady;

        hit = w_in_box && (w_twice <= {{(CW+1-D_W){1'b0}}, w_span});
    end

endmodule

`default_nettype wire

// File: rtl/vga_graph.sv
//------------------------------------------------------------------------------
// Module : vga_graph
// Brief  : 256x256 raster colouring node markers white and tour edges green.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vga_graph
    import vga_graph_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_NODES-1:0][COORD_W-1:0]  xs,
    input  logic [N_NODES-1:0][COORD_W-1:0]  ys,
    input  logic [N_NODES-1:0][IDX_W-1:0]    path,
    output logic [COLOR_W-1:0]               R,
    output logic [COLOR_W-1:0]               G,
    output logic [COLOR_W-1:0]               B
);

    coord_t             r_px, r_py;
    logic [N_NODES-1:0] w_node_hit;
    logic [N_NODES-1:0] w_seg_hit;

    generate
        for (genvar i = 0; i < N_NODES; i++) begin : g_node
            coord_t w_ddx, w_ddy;
            assign w_ddx = (r_px >= xs[i]) ? (r_px - xs[i]) : (xs[i] - r_px);
            assign w_ddy = (r_py >= ys[i]) ? (r_py - ys[i]) : (ys[i] - r_py);
            assign w_node_hit[i] = (w_ddx <= coord_t'(1)) && (w_ddy <= coord_t'(1));
        end

        // The last segment closes the tour back to path[0].
        for (genvar k = 0; k < N_NODES; k++) begin : g_seg
            localparam int KN = (k + 1) % N_NODES;
            idx_t w_a, w_b;
            assign w_a = path[k];
            assign w_b = path[KN];

            vga_graph_seg_hit u_seg_hit (
                .px  (r_px),
                .py  (r_py),
                .xa  (xs[w_a]),
                .ya  (ys[w_a]),
                .xb  (xs[w_b]),
                .yb  (ys[w_b]),
                .hit (w_seg_hit[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_px <= '0;
            r_py <= '0;
            R    <= COL_BLACK;
            G    <= COL_BLACK;
            B    <= COL_BLACK;
        end else begin
            r_px <= r_px + coord_t'(1);
            if (r_px == '1)
                r_py <= r_py + coord_t'(1);

            if (|w_node_hit) begin
                R <= COL_WHITE;
                G <= COL_WHITE;
                B <= COL_WHITE;
            end else if (|w_seg_hit) begin
                R <= COL_BLACK;
                G <= COL_GREEN;
                B <= COL_BLACK;
            end else begin
                R <= COL_BLACK;
                G <= COL_BLACK;
                B <= COL_BLACK;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_graph.sv
//------------------------------------------------------------------------------
// Module : tb_vga_graph
// Brief  : Self-checking bench for vga_graph against a behavioural raster model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vga_graph;
    import vga_graph_pkg::*;

    localparam logic [47:0] C_WHITE = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    localparam logic [47:0] C_GREEN = {16'h0000, 16'hFFFF, 16'h0000};
    localparam logic [47:0] C_BLACK = 48'h0;

    logic                            clk = 1'b0;
    logic                            rst = 1'b0;
    logic [N_NODES-1:0][COORD_W-1:0] xs;
    logic [N_NODES-1:0][COORD_W-1:0] ys;
    logic [N_NODES-1:0][IDX_W-1:0]   path;
    logic [COLOR_W-1:0]              R, G, B;

    int nx [N_NODES];
    int ny [N_NODES];
    int np [N_NODES];
    int n_checks = 0;
    int n_errors = 0;
    int edges    = 0;

    always #5 clk = ~clk;

    vga_graph dut (
        .clk  (clk),
        .rst  (rst),
        .xs   (xs),
        .ys   (ys),
        .path (path),
        .R    (R),
        .G    (G),
        .B    (B)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference colour straight from the geometric definition of markers and tour segments.
    function automatic logic [47:0] model_color(input int x, input int y);
        bit on_node = 1'b0;
        bit on_seg  = 1'b0;
        for (int i = 0; i < N_NODES; i++)
            if (iabs(x - nx[i]) <= 1 && iabs(y - ny[i]) <= 1) on_node = 1'b1;
        for (int k = 0; k < N_NODES; k++) begin
            int a, b, dx, dy, cr;
            a  = np[k];
            b  = np[(k + 1) % N_NODES];
            dx = nx[b] - nx[a];
            dy = ny[b] - ny[a];
            cr = (x - nx[a]) * dy - (y - ny[a]) * dx;
            if (x >= imin(nx[a], nx[b]) && x <= imax(nx[a], nx[b]) &&
                y >= imin(ny[a], ny[b]) && y <= imax(ny[a], ny[b]) &&
                iabs(2 * cr) <= imax(iabs(dx), iabs(dy)))
                on_seg = 1'b1;
        end
        if (on_node) return C_WHITE;
        if (on_seg)  return C_GREEN;
        return C_BLACK;
    endfunction

    task automatic apply();
        for (int i = 0; i < N_NODES; i++) begin
            xs[i]   = COORD_W'(nx[i]);
            ys[i]   = COORD_W'(ny[i]);
            path[i] = IDX_W'(np[i]);
        end
    endtask

    task automatic set_all(input int x, input int y);
        for (int i = 0; i < N_NODES; i++) begin
            nx[i] = x;
            ny[i] = y;
            np[i] = i;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("reset_rgb", {R, G, B}, C_BLACK);
        end
        rst   = 1'b1;
        edges = 0;
    endtask

    // One clock; the output now shows pixel edges-1 of the scan.
    task automatic step();
        int idx;
        @(posedge clk);
        #1;
        edges++;
        idx = (edges - 1) % 65536;
        check($sformatf("pix(%0d,%0d)", idx % 256, idx / 256), {R, G, B},
              model_color(idx % 256, idx / 256));
    endtask

    task automatic goto_pixel(input int target);
        while (edges - 1 < target) step();
    endtask

    task automatic spot(input string tag, input int target, input logic [47:0] exp);
        goto_pixel(target);
        check(tag, {R, G, B}, exp);
    endtask

    initial begin
        set_all(0, 0);
        apply();

        // Single cluster
        set_all(10, 10);
        apply();
        do_reset(3);
        spot("clu_8_8",   8 * 256 + 8,  C_BLACK);
        spot("clu_9_9",   9 * 256 + 9,  C_WHITE);
        spot("clu_11_9",  9 * 256 + 11, C_WHITE);
        spot("clu_10_10", 10 * 256 + 10, C_WHITE);
        spot("clu_12_10", 10 * 256 + 12, C_BLACK);
        spot("clu_9_11",  11 * 256 + 9,  C_WHITE);
        spot("clu_11_11", 11 * 256 + 11, C_WHITE);

        // Horizontal edge
        set_all(0, 0);
        nx[1] = 100;
        apply();
        do_reset(2);
        spot("hor_50_0",  50,            C_GREEN);
        spot("hor_101_0", 101,           C_WHITE);
        spot("hor_102_0", 102,           C_BLACK);
        spot("hor_50_1",  256 + 50,      C_BLACK);
        spot("hor_100_1", 256 + 100,     C_WHITE);

        // Diagonal edge
        set_all(0, 0);
        nx[1] = 32;
        ny[1] = 27;
        apply();
        do_reset(2);
        spot("dia_16_13", 13 * 256 + 16, C_GREEN);
        spot("dia_16_20", 20 * 256 + 16, C_BLACK);
        spot("dia_33_28", 28 * 256 + 33, C_WHITE);

        // Reversed path order draws the same tour, then a mid-frame node move
        for (int k = 0; k < N_NODES; k++) np[k] = 0;
        np[0] = 1;
        apply();
        do_reset(2);
        spot("ord_16_12", 12 * 256 + 16, C_BLACK);
        spot("ord_15_13", 13 * 256 + 15, C_GREEN);
        nx[1] = 200;
        ny[1] = 200;
        apply();
        spot("ord_moved_16_13", 13 * 256 + 16, C_BLACK);
        goto_pixel(13 * 256 + 16 + 500);

        // Random tour in the top rows, with a reset asserted mid-frame
        for (int i = 0; i < N_NODES; i++) begin
            nx[i] = $urandom_range(0, 255);
            ny[i] = $urandom_range(0, 5);
            np[i] = $urandom_range(0, N_NODES - 1);
        end
        apply();
        do_reset(2);
        goto_pixel(999);
        do_reset(1);
        goto_pixel(1535);

        // Full-load stress over more than one frame
        for (int i = 0; i < N_NODES; i++) begin
            nx[i] = (32 * i) % 256;
            ny[i] = (27 * i) % 256;
            np[i] = i;
        end
        apply();
        do_reset(3);
        spot("str_first_0_0", 0,         C_WHITE);
        spot("str_16_13",     13 * 256 + 16, C_GREEN);
        spot("str_32_27",     27 * 256 + 32, C_WHITE);
        goto_pixel(65535);
        spot("str_wrap_0_0",  65536,     C_WHITE);
        goto_pixel(69999);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
